// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: layer geometry constants, weight word type
// and the weight-loader state encoding.
package cnn_pkg;

    localparam int CONV2_KSIZE         = 25;
    localparam int CONV2_NUM_K         = 6;
    localparam int CONV2_K_WORDS       = CONV2_KSIZE * CONV2_NUM_K;
    localparam int CONV2_K_PAIR_OFFSET = CONV2_K_WORDS / 2;

    localparam int WEIGHT_W = 16;

    typedef logic [WEIGHT_W-1:0] weight_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } k_wr_state_t;

endpackage

// File: rtl/tap_kernel_counter.sv
// Nested tap/kernel counter for kernel-major weight streams; kernel saturates
// on the last word so it keeps naming the final kernel once the load completes.
module tap_kernel_counter #(
    parameter int KSIZE = 25,
    parameter int NUM_K = 6,
    parameter int TAP_W = $clog2(KSIZE),
    parameter int K_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [TAP_W-1:0] tap,
    output logic [K_W-1:0]   kernel,
    output logic             wrap,
    output logic             last
);

    assign wrap = (tap == TAP_W'(KSIZE - 1));
    assign last = wrap && (kernel == K_W'(NUM_K - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            tap    <= '0;
            kernel <= '0;
        end else if (inc) begin
            if (wrap) begin
                tap <= '0;
                if (!last)
                    kernel <= kernel + 1'b1;
            end else begin
                tap <= tap + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv2_k_mem_write.sv
// Streams the conv2 kernel weights into the weight memory, kernel-major from
// address 0, and raises done once every word has been written.
module conv2_k_mem_write
    import cnn_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int KSIZE  = CONV2_KSIZE,
    parameter int NUM_K  = CONV2_NUM_K,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        kernel_idx,
    output logic              busy,
    output logic              done
);

    localparam int TAP_W = $clog2(KSIZE);

    k_wr_state_t       state, next_state;
    logic              xfer;
    logic              load_clear;
    logic              last_word;
    logic              tap_wrap;
    logic [TAP_W-1:0]  tap;
    logic [ADDR_W-1:0] addr_cnt;
    logic              unused_cnt;

    assign in_ready   = (state == LOAD);
    assign busy       = (state == LOAD) || (state == DRAIN);
    assign xfer       = in_valid && in_ready;
    assign unused_cnt = ^{tap, tap_wrap};

    tap_kernel_counter #(
        .KSIZE (KSIZE),
        .NUM_K (NUM_K),
        .TAP_W (TAP_W),
        .K_W   (3)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (load_clear),
        .inc    (xfer),
        .tap    (tap),
        .kernel (kernel_idx),
        .wrap   (tap_wrap),
        .last   (last_word)
    );

    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        next_state = state;
        load_clear = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = LOAD;
                    load_clear = 1'b1;
                end
            end
            LOAD:    if (xfer && last_word) next_state = DRAIN;
            DRAIN:   next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            addr_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            state  <= next_state;
            mem_we <= xfer;
            done   <= (next_state == DONE);
            // Address runs as its own counter so no 25*k multiplier is needed.
            if (load_clear)
                addr_cnt <= '0;
            else if (xfer)
                addr_cnt <= addr_cnt + 1'b1;
            if (xfer) begin
                mem_addr  <= addr_cnt;
                mem_wdata <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_conv2_k_mem_write.sv
// Directed/randomized bench for conv2_k_mem_write against a word-count based
// reference model and a shadow copy of the weight memory.
module tb_conv2_k_mem_write;
    import cnn_pkg::*;

    localparam int WORDS  = 150;
    localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_DONE = 3;

    logic       clk = 1'b0;
    logic       reset, start, in_valid;
    weight_t    in_data;
    logic       in_ready, mem_we, busy, done;
    logic [7:0] mem_addr;
    weight_t    mem_wdata;
    logic [2:0] kernel_idx;

    int total = 0;
    int bad   = 0;

    // Reference model: load phase, words accepted so far, expected write port.
    int      phase;
    int      n;
    int      writes;
    logic    m_we;
    int      m_addr;
    weight_t m_wdata;
    weight_t exp_mem [WORDS];
    weight_t got_mem [WORDS];

    conv2_k_mem_write dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .kernel_idx (kernel_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("mem_we",     32'(mem_we),     32'(m_we));
        chk("mem_addr",   32'(mem_addr),   32'(m_addr));
        chk("mem_wdata",  32'(mem_wdata),  32'(m_wdata));
        chk("kernel_idx", 32'(kernel_idx), (n >= WORDS) ? 32'd5 : 32'(n / 25));
        chk("busy",       32'(busy),       32'(phase == P_LOAD || phase == P_DRAIN));
        chk("done",       32'(done),       32'(phase == P_DONE));
    endtask

    // One clock: drive inputs, check in_ready, advance model, check outputs.
    task automatic tick(input logic v, input weight_t d, input logic s, input logic r);
        in_valid = v;
        in_data  = d;
        start    = s;
        reset    = r;
        #1;
        chk("in_ready", 32'(in_ready), 32'(phase == P_LOAD));
        if (r) begin
            phase   = P_IDLE;
            n       = 0;
            m_we    = 1'b0;
            m_addr  = 0;
            m_wdata = '0;
        end else begin
            m_we = v && (phase == P_LOAD);
            if (m_we) begin
                m_addr     = n;
                m_wdata    = d;
                exp_mem[n] = d;
                n++;
            end
            case (phase)
                P_LOAD:  if (n == WORDS) phase = P_DRAIN;
                P_DRAIN: phase = P_DONE;
                default: if (s) begin phase = P_LOAD; n = 0; end
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (mem_we === 1'b1 && mem_addr < 8'(WORDS)) begin
            got_mem[mem_addr] = mem_wdata;
            writes++;
        end
    endtask

    // mode 0: valid held high, 1: toggling, 2: random bubbles.
    task automatic run_load(input int mode, input int base, input bit rnd,
                            input int abort_at, input bit extra_start);
        int   cyc;
        logic tog;
        logic v, s;
        weight_t d;
        writes = 0;
        cyc    = 0;
        tog    = 1'b1;
        tick(1'b0, '0, 1'b1, 1'b0);
        while (phase != P_DONE && cyc < 2000) begin
            if (abort_at >= 0 && n == abort_at && phase == P_LOAD) begin
                tick(1'b0, '0, 1'b0, 1'b1);
                return;
            end
            v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            d = rnd ? weight_t'($urandom) : weight_t'(base + n);
            s = extra_start && ((phase == P_LOAD && n == 40) || phase == P_DRAIN);
            tick(v, d, s, 1'b0);
            tog = ~tog;
            cyc++;
        end
        chk("load_done", 32'(done), 32'd1);
        chk("write_count", 32'(writes), 32'(WORDS));
        for (int i = 0; i < WORDS; i++)
            chk($sformatf("mem[%0d]", i), 32'(got_mem[i]), 32'(exp_mem[i]));
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        phase    = P_IDLE;
        n        = 0;
        writes   = 0;
        m_we     = 1'b0;
        m_addr   = 0;
        m_wdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        chk("reset_in_ready", 32'(in_ready), 32'd0);

        repeat (10) tick(1'b1, weight_t'($urandom), 1'b0, 1'b0);
        run_load(0, 'h100, 1'b0, -1, 1'b0);
        run_load(1, 0, 1'b1, -1, 1'b0);
        repeat (10) tick(1'b1, weight_t'($urandom), 1'b0, 1'b0);
        run_load(2, 0, 1'b1, -1, 1'b1);
        run_load(2, 0, 1'b1, 60, 1'b0);
        repeat (3) tick(1'b1, weight_t'($urandom), 1'b0, 1'b0);
        run_load(1, 'h200, 1'b0, -1, 1'b0);
        run_load(0, 'hA000, 1'b0, -1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b1);
        repeat (2) tick(1'b1, weight_t'($urandom), 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
